// File: rtl/cache_fill_arbiter.sv
// ---------------------------------------------------------------------------
// cache_fill_arbiter
//
// Miss-handling controller that shares one pipelined main memory between the
// I-cache (fetch stage) and the D-cache (memory stage). One miss is granted at
// a time. The controller issues WORDS_PER_BLK sequential word reads for the
// block-aligned address, streams the returned words into the granted cache
// with a word index, and then pulses that cache's done so its stall releases.
//
// Optional feature macro: FILL_ARB_ROUND_ROBIN_EN
//   undefined : fixed priority, D-cache wins a simultaneous request
//   defined   : a last_grant flop alternates simultaneous requests
//
// Ports:
//   clk            in   system clock
//   rst            in   asynchronous active-high reset
//   i_miss         in   I-cache miss request (level, held until i_fill_done)
//   i_miss_addr    in   I-cache miss address
//   d_miss         in   D-cache miss request (level, held until d_fill_done)
//   d_miss_addr    in   D-cache miss address
//   mem_data_valid in   read data valid (in issue order, fixed latency >= 1)
//   mem_data       in   read data
//   mem_en         out  read strobe, one word per cycle
//   mem_addr       out  read address
//   fill_data      out  word written into the granted cache
//   fill_word      out  index of fill_data within the block
//   i_fill_wen     out  I-cache data-array write enable
//   d_fill_wen     out  D-cache data-array write enable
//   i_fill_done    out  one-cycle pulse, I-cache block complete
//   d_fill_done    out  one-cycle pulse, D-cache block complete
//   busy           out  high whenever the controller is not idle
// ---------------------------------------------------------------------------
module cache_fill_arbiter #(
    parameter int WORDS_PER_BLK = 8,
    parameter int ADDR_W        = 16,
    parameter int DATA_W        = 16
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             i_miss,
    input  logic [ADDR_W-1:0]                i_miss_addr,
    input  logic                             d_miss,
    input  logic [ADDR_W-1:0]                d_miss_addr,
    input  logic                             mem_data_valid,
    input  logic [DATA_W-1:0]                mem_data,
    output logic                             mem_en,
    output logic [ADDR_W-1:0]                mem_addr,
    output logic [DATA_W-1:0]                fill_data,
    output logic [$clog2(WORDS_PER_BLK)-1:0] fill_word,
    output logic                             i_fill_wen,
    output logic                             d_fill_wen,
    output logic                             i_fill_done,
    output logic                             d_fill_done,
    output logic                             busy
);

    localparam int IDX_W = $clog2(WORDS_PER_BLK);
    // Counters need one extra bit so the issue side can hold WORDS_PER_BLK.
    localparam int CNT_W = IDX_W + 1;

    localparam logic [CNT_W-1:0]  WORDS_CNT = CNT_W'(WORDS_PER_BLK);
    localparam logic [CNT_W-1:0]  LAST_WORD = CNT_W'(WORDS_PER_BLK - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    // Block is 2*WORDS_PER_BLK bytes, so the low log2 of that many bits are
    // the byte offset inside the block and get cleared to form the base.
    localparam logic [ADDR_W-1:0] BLK_MASK  = ~ADDR_W'(2 * WORDS_PER_BLK - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef enum logic {
        GRANT_I = 1'b0,
        GRANT_D = 1'b1
    } grant_t;

    state_t            state_q,    state_d;
    grant_t            grant_q,    grant_d;
    logic [ADDR_W-1:0] base_q,     base_d;
    logic [CNT_W-1:0]  issueCnt_q, issueCnt_d;
    logic [CNT_W-1:0]  recvCnt_q,  recvCnt_d;

    grant_t            pickGrant;
    logic              anyMiss;

`ifdef FILL_ARB_ROUND_ROBIN_EN
    grant_t            lastGrant_q, lastGrant_d;
`endif

    // Arbitration between the two requesters. A lone request is always
    // granted; a simultaneous pair is resolved either by fixed D priority or
    // by handing the grant to whoever did not get the previous one.
    always_comb begin
        anyMiss   = i_miss | d_miss;
        pickGrant = GRANT_I;
        if (i_miss && d_miss) begin
`ifdef FILL_ARB_ROUND_ROBIN_EN
            pickGrant = (lastGrant_q == GRANT_D) ? GRANT_I : GRANT_D;
`else
            pickGrant = GRANT_D;
`endif
        end else if (d_miss) begin
            pickGrant = GRANT_D;
        end
    end

    // State, grant, base address and both counters. Reset is asynchronous so
    // an abort mid-fill takes effect within the reset cycle itself.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            grant_q    <= GRANT_I;
            base_q     <= '0;
            issueCnt_q <= '0;
            recvCnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            base_q     <= base_d;
            issueCnt_q <= issueCnt_d;
            recvCnt_q  <= recvCnt_d;
        end
    end

`ifdef FILL_ARB_ROUND_ROBIN_EN
    // Remembers who won the most recent grant for round-robin tie breaking.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lastGrant_q <= GRANT_I;
        end else begin
            lastGrant_q <= lastGrant_d;
        end
    end

    // The last-grant record only changes on an actual grant out of IDLE.
    always_comb begin
        lastGrant_d = lastGrant_q;
        if (state_q == IDLE && anyMiss) begin
            lastGrant_d = pickGrant;
        end
    end
`endif

    // Next-state and output logic. Outputs that carry addresses, data or word
    // indices are forced to zero whenever their strobe is low so that idle
    // and reset cycles present a clean all-zero interface.
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        base_d      = base_q;
        issueCnt_d  = issueCnt_q;
        recvCnt_d   = recvCnt_q;

        mem_en      = 1'b0;
        mem_addr    = '0;
        fill_data   = '0;
        fill_word   = '0;
        i_fill_wen  = 1'b0;
        d_fill_wen  = 1'b0;
        i_fill_done = 1'b0;
        d_fill_done = 1'b0;
        busy        = (state_q != IDLE);

        case (state_q)
            IDLE: begin
                // Stray memory data here is deliberately ignored.
                if (anyMiss) begin
                    grant_d    = pickGrant;
                    base_d     = ((pickGrant == GRANT_D) ? d_miss_addr : i_miss_addr) & BLK_MASK;
                    issueCnt_d = '0;
                    recvCnt_d  = '0;
                    state_d    = FILL;
                end
            end

            FILL: begin
                // Issue side runs ahead of the receive side by the memory
                // latency; base is block aligned so the offset never carries
                // out of the block.
                if (issueCnt_q < WORDS_CNT) begin
                    mem_en     = 1'b1;
                    mem_addr   = base_q + ADDR_W'({issueCnt_q, 1'b0});
                    issueCnt_d = issueCnt_q + CNT_ONE;
                end

                if (mem_data_valid) begin
                    fill_data = mem_data;
                    fill_word = recvCnt_q[IDX_W-1:0];
                    if (grant_q == GRANT_D) begin
                        d_fill_wen = 1'b1;
                    end else begin
                        i_fill_wen = 1'b1;
                    end
                    recvCnt_d = recvCnt_q + CNT_ONE;
                    if (recvCnt_q == LAST_WORD) begin
                        state_d = DONE;
                    end
                end
            end

            DONE: begin
                if (grant_q == GRANT_D) begin
                    d_fill_done = 1'b1;
                end else begin
                    i_fill_done = 1'b1;
                end
                issueCnt_d = '0;
                recvCnt_d  = '0;
                state_d    = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_cache_fill_arbiter.sv
// ---------------------------------------------------------------------------
// tb_cache_fill_arbiter
//
// Self-checking bench for cache_fill_arbiter. A memory responder returns the
// data for each issued read after a configurable fixed latency; the data word
// is a salted hash of the address so a wrong address also shows up as wrong
// fill data. Expected behaviour for each block fill is derived from the
// cycle timeline of a miss (issue in cycles 1..8, writes in 1+L..8+L, done
// in 9+L) rather than from the design's internals.
// ---------------------------------------------------------------------------
module tb_cache_fill_arbiter;

    logic        clk;
    logic        rst;
    logic        i_miss;
    logic [15:0] i_miss_addr;
    logic        d_miss;
    logic [15:0] d_miss_addr;
    logic        mem_data_valid;
    logic [15:0] mem_data;
    logic        mem_en;
    logic [15:0] mem_addr;
    logic [15:0] fill_data;
    logic [2:0]  fill_word;
    logic        i_fill_wen;
    logic        d_fill_wen;
    logic        i_fill_done;
    logic        d_fill_done;
    logic        busy;

    int          assertCount = 0;
    int          failCount   = 0;
    int          cycle       = 0;
    int          memLat      = 1;
    logic [15:0] memSalt     = 16'h0;
    bit          injectValid = 1'b0;
    bit          lastGrantD  = 1'b0;

    logic [15:0] pendAddr[$];
    int          pendDue[$];

    cache_fill_arbiter #(
        .WORDS_PER_BLK(8),
        .ADDR_W(16),
        .DATA_W(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .i_miss(i_miss),
        .i_miss_addr(i_miss_addr),
        .d_miss(d_miss),
        .d_miss_addr(d_miss_addr),
        .mem_data_valid(mem_data_valid),
        .mem_data(mem_data),
        .mem_en(mem_en),
        .mem_addr(mem_addr),
        .fill_data(fill_data),
        .fill_word(fill_word),
        .i_fill_wen(i_fill_wen),
        .d_fill_wen(d_fill_wen),
        .i_fill_done(i_fill_done),
        .d_fill_done(d_fill_done),
        .busy(busy)
    );

    // Free-running clock and a cycle counter used for memory timing.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    // Contents of main memory as seen by the bench.
    function automatic logic [15:0] memWord(input logic [15:0] a);
        return (a * 16'h9E37) ^ memSalt;
    endfunction

    // Winner of a simultaneous I/D request under the configured policy.
    function automatic bit bothWinnerIsD();
`ifdef FILL_ARB_ROUND_ROBIN_EN
        return !lastGrantD;
`else
        return 1'b1;
`endif
    endfunction

    // Pipelined memory: reads seen mid-cycle are answered memLat cycles later,
    // in order. In-flight reads survive a controller reset, like real memory.
    initial begin
        mem_data_valid = 1'b0;
        mem_data       = 16'h0;
        forever begin
            @(negedge clk);
            if (mem_en === 1'b1) begin
                pendAddr.push_back(mem_addr);
                pendDue.push_back(cycle + memLat);
            end
            @(posedge clk);
            #1;
            mem_data_valid = 1'b0;
            mem_data       = 16'h0;
            if (pendDue.size() > 0 && pendDue[0] == cycle) begin
                mem_data_valid = 1'b1;
                mem_data       = memWord(pendAddr[0]);
                void'(pendDue.pop_front());
                void'(pendAddr.pop_front());
            end else if (injectValid) begin
                mem_data_valid = 1'b1;
                mem_data       = 16'($urandom);
            end
        end
    end

    // Guard against a hung run.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        assertCount++;
        assert (obs === exp) else begin
            failCount++;
            $error("[TB] FAIL %s at cycle %0d: observed=%0h expected=%0h", tag, cycle, obs, exp);
        end
    endtask

    // Presents a new request pattern right after a clock edge; the cycle that
    // follows is cycle 0 of the miss timeline.
    task automatic applyStimulus(input bit iReq, input logic [15:0] iAddr,
                                 input bit dReq, input logic [15:0] dAddr);
        @(posedge clk);
        #1;
        i_miss      = iReq;
        i_miss_addr = iAddr;
        d_miss      = dReq;
        d_miss_addr = dAddr;
    endtask

    // Checks one complete block fill. Must be entered during cycle 0 (the
    // IDLE cycle that samples the miss); returns just after the requester has
    // dropped its miss at the edge that sampled done.
    task automatic runFill(input bit grantD, input logic [15:0] missAddr, input int lat,
                           input bit doChange, input logic [15:0] altAddr);
        logic [15:0] base;
        bit          expW;
        bit          expDone;
        int          r;
        base       = missAddr & 16'hFFF0;
        lastGrantD = grantD;
        for (int c = 1; c <= 9 + lat; c++) begin
            @(posedge clk);
            @(negedge clk);
            expW    = (c >= 1 + lat) && (c <= 8 + lat);
            expDone = (c == 9 + lat);
            checkOutput("mem_en", {31'b0, mem_en}, {31'b0, (c <= 8)});
            if (c <= 8) begin
                checkOutput("mem_addr", {16'b0, mem_addr}, {16'b0, base + 16'(2 * (c - 1))});
            end
            checkOutput("i_fill_wen", {31'b0, i_fill_wen}, {31'b0, expW && !grantD});
            checkOutput("d_fill_wen", {31'b0, d_fill_wen}, {31'b0, expW && grantD});
            if (expW) begin
                r = c - 1 - lat;
                checkOutput("fill_word", {29'b0, fill_word}, r);
                checkOutput("fill_data", {16'b0, fill_data}, {16'b0, memWord(base + 16'(2 * r))});
            end
            checkOutput("i_fill_done", {31'b0, i_fill_done}, {31'b0, expDone && !grantD});
            checkOutput("d_fill_done", {31'b0, d_fill_done}, {31'b0, expDone && grantD});
            checkOutput("busy", {31'b0, busy}, 32'd1);
            if (doChange && c == 3) begin
                i_miss_addr = altAddr;
            end
        end
        @(posedge clk);
        #1;
        if (grantD) d_miss = 1'b0;
        else        i_miss = 1'b0;
        checkOutput("busy_after_done", {31'b0, busy}, 32'd0);
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_mem_en"},    {31'b0, mem_en},      32'd0);
        checkOutput({tag, "_mem_addr"},  {16'b0, mem_addr},    32'd0);
        checkOutput({tag, "_fill_data"}, {16'b0, fill_data},   32'd0);
        checkOutput({tag, "_fill_word"}, {29'b0, fill_word},   32'd0);
        checkOutput({tag, "_i_wen"},     {31'b0, i_fill_wen},  32'd0);
        checkOutput({tag, "_d_wen"},     {31'b0, d_fill_wen},  32'd0);
        checkOutput({tag, "_i_done"},    {31'b0, i_fill_done}, 32'd0);
        checkOutput({tag, "_d_done"},    {31'b0, d_fill_done}, 32'd0);
        checkOutput({tag, "_busy"},      {31'b0, busy},        32'd0);
    endtask

    initial begin
        rst         = 1'b1;
        i_miss      = 1'b0;
        i_miss_addr = 16'h0;
        d_miss      = 1'b0;
        d_miss_addr = 16'h0;
        memSalt     = 16'($urandom);

        // Reset state.
        #12;
        checkAllZero("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Single I-cache miss, latency 4.
        memLat = 4;
        applyStimulus(1'b1, 16'h1236, 1'b0, 16'h0);
        runFill(1'b0, 16'h1236, 4, 1'b0, 16'h0);

        // Simultaneous misses; the loser is held pending and granted next.
        memLat = 3;
        applyStimulus(1'b1, 16'h0040, 1'b1, 16'h8008);
        if (bothWinnerIsD()) begin
            runFill(1'b1, 16'h8008, 3, 1'b0, 16'h0);
            runFill(1'b0, 16'h0040, 3, 1'b0, 16'h0);
        end else begin
            runFill(1'b0, 16'h0040, 3, 1'b0, 16'h0);
            runFill(1'b1, 16'h8008, 3, 1'b0, 16'h0);
        end

        // Memory data arriving while idle must be ignored.
        @(negedge clk);
        injectValid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        injectValid = 1'b0;
        checkOutput("idle_valid_i_wen", {31'b0, i_fill_wen}, 32'd0);
        checkOutput("idle_valid_d_wen", {31'b0, d_fill_wen}, 32'd0);
        checkOutput("idle_valid_busy",  {31'b0, busy},       32'd0);

        // Miss address changes mid-fill; the next fill also proves the idle
        // data pulse did not advance the word counter.
        memLat = 2;
        applyStimulus(1'b1, 16'h2000, 1'b0, 16'h0);
        runFill(1'b0, 16'h2000, 2, 1'b1, 16'h3000);

        // Reset in the fifth FILL cycle with reads in flight.
        memLat = 2;
        applyStimulus(1'b0, 16'h0, 1'b1, 16'hABCD);
        for (int c = 1; c <= 4; c++) begin
            @(posedge clk);
            @(negedge clk);
            checkOutput("pre_rst_mem_en",   {31'b0, mem_en},     32'd1);
            checkOutput("pre_rst_mem_addr", {16'b0, mem_addr},   {16'b0, 16'hABC0 + 16'(2 * (c - 1))});
            checkOutput("pre_rst_d_wen",    {31'b0, d_fill_wen}, {31'b0, (c >= 3)});
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        checkAllZero("mid_rst");
        @(posedge clk);
        #1;
        rst        = 1'b0;
        lastGrantD = 1'b0;
        @(negedge clk);
        checkOutput("stale_i_wen", {31'b0, i_fill_wen}, 32'd0);
        checkOutput("stale_d_wen", {31'b0, d_fill_wen}, 32'd0);
        checkOutput("stale_busy",  {31'b0, busy},       32'd0);
        runFill(1'b1, 16'hABCD, 2, 1'b0, 16'h0);

        // Randomized traffic: latency, addresses and request pattern.
        for (int it = 0; it < 12; it++) begin
            int          kind;
            bit          winD;
            logic [15:0] ia;
            logic [15:0] da;
            memLat = $urandom_range(1, 6);
            kind   = $urandom_range(0, 2);
            ia     = 16'($urandom);
            da     = 16'($urandom);
            repeat ($urandom_range(0, 3)) @(posedge clk);
            case (kind)
                0: begin
                    applyStimulus(1'b1, ia, 1'b0, 16'h0);
                    runFill(1'b0, ia, memLat, 1'b0, 16'h0);
                end
                1: begin
                    applyStimulus(1'b0, 16'h0, 1'b1, da);
                    runFill(1'b1, da, memLat, 1'b0, 16'h0);
                end
                default: begin
                    winD = bothWinnerIsD();
                    applyStimulus(1'b1, ia, 1'b1, da);
                    if (winD) begin
                        runFill(1'b1, da, memLat, 1'b0, 16'h0);
                        runFill(1'b0, ia, memLat, 1'b0, 16'h0);
                    end else begin
                        runFill(1'b0, ia, memLat, 1'b0, 16'h0);
                        runFill(1'b1, da, memLat, 1'b0, 16'h0);
                    end
                end
            endcase
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
